gshare_predictor: RTL and testbench
===================================

Name: gshare_predictor

Overview:
- Branch direction predictor in the IF stage, directly upstream of the EX-stage mispredict comparator.
- Produces the prediction bit that the pipeline carries to EX as pred_bit_ex. It also produces the table index that travels with the instruction.
- Trains itself from the resolved outcome (PCsrc) when a branch reaches EX.
- Gshare scheme: 2-bit saturating counter table indexed by PC XOR global history, plus saturating branch/mispredict statistics counters.

Parameters:
- IDX_W, 6, table index width; table depth = 2^IDX_W entries.
- GHR_W, 6, global history length in bits; must be <= IDX_W (history is zero-extended into the index).
- PC_W, 32, program counter width.
- CNT_W, 32, statistics counter width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_if  input  PC_W  PC of instruction in IF.
- pred_bit  output  1  predicted direction for pc_if: 1 = taken.
- pred_idx  output  IDX_W  index used for pred_bit; pipelined with the instruction to EX.
- en_ex  input  1  instruction in EX is a conditional branch (same qualifier the comparator uses).
- pcsrc_ex  input  1  resolved direction in EX: 1 = taken.
- idx_ex  input  IDX_W  pred_idx carried to EX with that branch.
- miss_ex  input  1  mispredict flag from the comparator; only meaningful when en_ex = 1.
- br_count  output  CNT_W  number of resolved branches.
- miss_count  output  CNT_W  number of mispredicted branches.
- ghr  output  GHR_W  current global history (debug/visibility).

Behaviour:
- Reset (rst_n low, asynchronous):
  - every table entry = 2'b01 (weakly not-taken);
  - ghr = 0; br_count = 0; miss_count = 0;
  - pred_bit therefore reads 0 combinationally.
  - Reset is honoured mid-operation; no update in flight survives.
- Index:
  - pred_idx = pc_if[IDX_W+1:2] XOR {zero-extend(ghr)}.
  - PC bits [1:0] are ignored (word-aligned).
- Prediction:
  - Combinational, zero latency.
  - pred_bit = MSB of table[pred_idx].
  - Uses the state at the start of the cycle.
- Update: on a rising edge with en_ex = 1.
  - If pcsrc_ex = 1, table[idx_ex] increments, saturating at 2'b11.
  - If pcsrc_ex = 0, table[idx_ex] decrements, saturating at 2'b00.
  - Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  - ghr shifts left by one with pcsrc_ex entering the LSB; the MSB is dropped.
  - br_count increments, saturating at all-ones.
  - If miss_ex = 1, miss_count increments, saturating at all-ones.
- en_ex = 0: no state change; miss_ex and pcsrc_ex are ignored.
- Same-cycle read/write of the same entry (pred_idx == idx_ex with en_ex = 1):
  - pred_bit reflects the pre-update value (no bypass).
  - The new value is visible from the next cycle.
- History is non-speculative: it is updated only at EX resolution and needs no flush/recovery port.
- Table storage is flops (async reset required), not inferred RAM.
- Saturation is checked before increment for all counters; no wrap-around anywhere.

Test Plan:
- Reset check: assert rst_n = 0 mid-cycle, then release.
  - Required: pred_bit = 0 for any pc_if, ghr = 0, both counts = 0 immediately, without a clock edge.
- Training to taken: pc_if = 0x40 held, ghr held at 0.
  - Drive 3 updates with en_ex = 1, pcsrc_ex = 1, idx_ex = 0x10, reset ghr between updates.
  - Required: entry goes 01→10→11→11 (saturated); pred_bit for idx 0x10 becomes 1 after the first update.
- History shift and index XOR:
  - From reset, resolve taken, not-taken, taken.
  - Required: ghr = 6'b000101.
  - Required: pc_if = 0x40 then yields pred_idx = 0x10 ^ 0x05 = 0x15.
- Same-cycle hazard: entry 0x15 = 01, pred_idx = 0x15, update idx_ex = 0x15 taken in the same cycle.
  - Required: pred_bit = 0 that cycle, 1 the next.
- Statistics: 5 branches with miss_ex pattern 1,0,1,1,0, plus 2 cycles of en_ex = 0 with miss_ex = 1.
  - Required: br_count = 5, miss_count = 3.
- Saturation: use CNT_W = 4 and drive 20 mispredicted branches.
  - Required: br_count = miss_count = 15.
  - Also: a 00 entry decremented stays 00.

Source files
------------

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: 2-bit counters indexed by PC ^ global history,
// trained at EX resolution, with saturating branch/mispredict statistics.

module gshare_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd,
  input  logic       taken,
  output logic [1:0] ctr
);
  logic [1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (upd) begin
      if (taken && ctr_q != 2'b11)       ctr_d = ctr_q + 2'd1;
      else if (!taken && ctr_q != 2'b00) ctr_d = ctr_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctr_q <= 2'b01;
    else        ctr_q <= ctr_d;
  end

  assign ctr = ctr_q;
endmodule

module gshare_predictor #(
  parameter int IDX_W = 6,
  parameter int GHR_W = 6,
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  pc_if,
  output logic             pred_bit,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             en_ex,
  input  logic             pcsrc_ex,
  input  logic [IDX_W-1:0] idx_ex,
  input  logic             miss_ex,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [GHR_W-1:0] ghr
);
  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0][1:0] tbl;
  logic [GHR_W-1:0]      ghr_q, ghr_d;
  logic [CNT_W-1:0]      br_q, br_d, miss_q, miss_d;
  logic [IDX_W-1:0]      ghr_ext;
  logic                  unused_pc;

  // Word-aligned PC: low two bits and bits above the index never reach the table.
  assign unused_pc = ^{pc_if[PC_W-1:IDX_W+2], pc_if[1:0]};

  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_W-1:0] = ghr_q;
  end

  assign pred_idx = pc_if[IDX_W+1:2] ^ ghr_ext;
  // Read reflects state at start of cycle; a same-entry write lands next cycle.
  assign pred_bit = tbl[pred_idx][1];

  for (genvar g = 0; g < DEPTH; g++) begin : g_tbl
    gshare_ctr u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .upd   (en_ex && (idx_ex == IDX_W'(g))),
      .taken (pcsrc_ex),
      .ctr   (tbl[g])
    );
  end

  always_comb begin
    ghr_d  = ghr_q;
    br_d   = br_q;
    miss_d = miss_q;
    if (en_ex) begin
      ghr_d = (ghr_q << 1) | GHR_W'(pcsrc_ex);
      if (br_q != '1)             br_d   = br_q + 1'b1;
      if (miss_ex && miss_q != '1) miss_d = miss_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q  <= '0;
      br_q   <= '0;
      miss_q <= '0;
    end else begin
      ghr_q  <= ghr_d;
      br_q   <= br_d;
      miss_q <= miss_d;
    end
  end

  assign ghr        = ghr_q;
  assign br_count   = br_q;
  assign miss_count = miss_q;
endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor: stimulus queues expected values, monitor compares.

module tb_gshare_predictor;
  localparam int IDX_W = 6, GHR_W = 6, PC_W = 32, CNT_W = 4;
  localparam int K_PRED = 0, K_IDX = 1, K_GHR = 2, K_BR = 3, K_MISS = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [PC_W-1:0]  pc_if;
  logic             pred_bit;
  logic [IDX_W-1:0] pred_idx;
  logic             en_ex, pcsrc_ex, miss_ex;
  logic [IDX_W-1:0] idx_ex;
  logic [CNT_W-1:0] br_count, miss_count;
  logic [GHR_W-1:0] ghr;

  gshare_predictor #(.IDX_W(IDX_W), .GHR_W(GHR_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .pred_bit(pred_bit), .pred_idx(pred_idx),
    .en_ex(en_ex), .pcsrc_ex(pcsrc_ex), .idx_ex(idx_ex), .miss_ex(miss_ex),
    .br_count(br_count), .miss_count(miss_count), .ghr(ghr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  chk_t        sb[$];
  event        sample_ev;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [5:0]  m_ghr   = '0;

  function automatic logic [31:0] dut_val(int k);
    case (k)
      K_PRED:  return {31'b0, pred_bit};
      K_IDX:   return 32'(pred_idx);
      K_GHR:   return 32'(ghr);
      K_BR:    return 32'(br_count);
      default: return 32'(miss_count);
    endcase
  endfunction

  // Monitor: drains every queued expectation against the live DUT outputs.
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        c   = sb.pop_front();
        act = dut_val(c.kind);
        n_tests++;
        if (act !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic check(string nm, int k, logic [31:0] e);
    chk_t c;
    c.name = nm; c.kind = k; c.exp = e;
    sb.push_back(c);
    ->sample_ev;
    #1;
  endtask

  task automatic set_pc(logic [5:0] idx);
    pc_if = {24'h0, idx ^ m_ghr, 2'b00};
    #1;
  endtask

  task automatic upd(logic [5:0] idx, logic tk, logic ms);
    idx_ex = idx; pcsrc_ex = tk; miss_ex = ms; en_ex = 1'b1;
    @(posedge clk); #1;
    en_ex = 1'b0; miss_ex = 1'b0;
    m_ghr = {m_ghr[4:0], tk};
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0; m_ghr = '0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en_ex = 1'b0; pcsrc_ex = 1'b0; miss_ex = 1'b0;
    idx_ex = '0; pc_if = 32'h40;
    #12 rst_n = 1'b1;

    // Dirty some state, then reset mid-cycle and check without a clock edge.
    upd(6'h10, 1'b1, 1'b1);
    upd(6'h10, 1'b1, 1'b1);
    set_pc(6'h10);
    check("pre_reset_pred", K_PRED, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst_pred", K_PRED, 32'd0);
    check("rst_ghr", K_GHR, 32'd0);
    check("rst_br", K_BR, 32'd0);
    check("rst_miss", K_MISS, 32'd0);
    m_ghr = '0;
    rst_n = 1'b1;

    // Training entry 0x10 towards taken, re-aiming pc_if as ghr moves.
    pc_if = 32'h40; #1;
    check("train_idx0", K_IDX, 32'h10);
    check("train_pred0", K_PRED, 32'd0);
    upd(6'h10, 1'b1, 1'b0); set_pc(6'h10); check("train_t1", K_PRED, 32'd1);
    upd(6'h10, 1'b1, 1'b0); set_pc(6'h10); check("train_t2", K_PRED, 32'd1);
    upd(6'h10, 1'b1, 1'b0); set_pc(6'h10); check("train_t3_sat", K_PRED, 32'd1);
    upd(6'h10, 1'b0, 1'b0); set_pc(6'h10); check("train_n1", K_PRED, 32'd1);
    upd(6'h10, 1'b0, 1'b0); set_pc(6'h10); check("train_n2", K_PRED, 32'd0);
    check("train_ghr", K_GHR, 32'h1C);

    // History shift and index XOR.
    do_reset();
    upd(6'h00, 1'b1, 1'b0);
    upd(6'h01, 1'b0, 1'b0);
    upd(6'h02, 1'b1, 1'b0);
    check("hist_ghr", K_GHR, 32'h05);
    pc_if = 32'h40; #1;
    check("hist_idx", K_IDX, 32'h15);
    check("hist_pred", K_PRED, 32'd0);
    pc_if = 32'hFFFF_FF43; #1;
    check("hist_idx_hibits", K_IDX, 32'h15);

    // Same-cycle read/write of entry 0x15: no bypass.
    pc_if = 32'h40;
    idx_ex = 6'h15; pcsrc_ex = 1'b1; miss_ex = 1'b0; en_ex = 1'b1;
    #1;
    check("hazard_same", K_PRED, 32'd0);
    @(posedge clk); #1;
    en_ex = 1'b0;
    m_ghr = {m_ghr[4:0], 1'b1};
    set_pc(6'h15);
    check("hazard_next_idx", K_IDX, 32'h15);
    check("hazard_next", K_PRED, 32'd1);

    // Statistics and idle cycles with stray miss/pcsrc.
    do_reset();
    upd(6'h01, 1'b1, 1'b1);
    upd(6'h02, 1'b1, 1'b0);
    upd(6'h03, 1'b0, 1'b1);
    upd(6'h04, 1'b1, 1'b1);
    upd(6'h05, 1'b0, 1'b0);
    idx_ex = 6'h3F; pcsrc_ex = 1'b1; miss_ex = 1'b1; en_ex = 1'b0;
    repeat (2) @(posedge clk);
    #1 miss_ex = 1'b0;
    check("stat_br", K_BR, 32'd5);
    check("stat_miss", K_MISS, 32'd3);
    check("stat_ghr_idle", K_GHR, 32'h1A);
    set_pc(6'h3F);
    check("stat_tbl_idle", K_PRED, 32'd0);

    // History drops its MSB.
    do_reset();
    repeat (7) upd(6'h20, 1'b1, 1'b0);
    check("ghr_full", K_GHR, 32'h3F);
    upd(6'h20, 1'b0, 1'b0);
    check("ghr_drop", K_GHR, 32'h3E);
    set_pc(6'h20);
    check("ghr_entry", K_PRED, 32'd1);

    // Counter saturation and table floor.
    do_reset();
    repeat (20) upd(6'h00, 1'b0, 1'b1);
    check("sat_br", K_BR, 32'd15);
    check("sat_miss", K_MISS, 32'd15);
    check("sat_ghr", K_GHR, 32'd0);
    set_pc(6'h00);
    check("floor_pred", K_PRED, 32'd0);
    upd(6'h00, 1'b1, 1'b0); set_pc(6'h00); check("floor_inc1", K_PRED, 32'd0);
    upd(6'h00, 1'b1, 1'b0); set_pc(6'h00); check("floor_inc2", K_PRED, 32'd1);
    check("sat_br_hold", K_BR, 32'd15);

    #2;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
